chip8_mem_arbiter: RTL and testbench
====================================

Name: chip8_mem_arbiter

Overview:
- Arbitrates the single-port CHIP-8 main RAM (4 KiB, synchronous read, 1-cycle q latency) between two requesters: the CPU (read/write) and the VGA pixel generator (read-only framebuffer fetch).
- Removes the current conflict where both requesters drive the RAM read address.
- Sits between chip8_cpu, pixel_generator and chip8_ram in fpga_chip8.
- Video has fixed priority, subject to a starvation guard; at most one RAM access is issued per cycle, fully pipelined.

Parameters:
- ADDR_W, 12, RAM address width.
- DATA_W, 8, RAM data width.
- MAX_VID_STREAK, 4, maximum consecutive video grants while a CPU request is pending; range 1..15.

Ports:
- clk  in  1  system clock; all requesters run on clk and use clock enables where needed.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held with address/data until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  one-cycle pulse: CPU request accepted.
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid.
- cpu_rdata  out  DATA_W  CPU read data; holds its value between reads.
- vid_req  in  1  video read request.
- vid_addr  in  ADDR_W  video address.
- vid_gnt  out  1  one-cycle pulse: video request accepted.
- vid_rvalid  out  1  one-cycle pulse: vid_rdata valid.
- vid_rdata  out  DATA_W  video read data; holds its value between reads.
- ram_addr  out  ADDR_W  RAM address; drives both read_address and write_address.
- ram_we  out  1  RAM write enable.
- ram_d  out  DATA_W  RAM write data.
- ram_q  in  DATA_W  RAM read data.

Behaviour:
- Reset (reset=0, async): all outputs 0, streak counter 0, read pipeline tags cleared. Reads in flight are dropped, and no rvalid is produced for them after reset release.
- Arbitration at each rising edge E0, when any req=1:
  - Winner is video if vid_req=1 and (cpu_req=0 or streak<MAX_VID_STREAK); otherwise the winner is CPU.
  - The winner's address/we/data are registered onto ram_addr/ram_we/ram_d at E0.
  - The winner's gnt=1 for the cycle after E0; the loser's gnt=0.
  - ram_we=1 only for a CPU write. It is 0 for every read and for idle cycles.
- Streak counter:
  - Increments on each video grant while cpu_req=1.
  - Resets to 0 on any CPU grant or any cycle with cpu_req=0.
  - Saturates at MAX_VID_STREAK.
- Handshake:
  - Requester must keep req/addr/wdata stable until it sees gnt.
  - During the gnt cycle the requester may change addr, or drop req, combinationally before the next edge.
  - A req still high at the next edge is a new request and can be granted back-to-back (one access per cycle per requester).
- Read latency:
  - RAM samples ram_addr at E1 (the edge ending the gnt cycle).
  - Arbiter captures ram_q into the owner's rdata at E2.
  - Owner's rvalid is high in the cycle after E2, i.e. 2 cycles after the gnt cycle.
  - A 2-stage owner tag pipeline (none/cpu/vid) routes the data. Interleaved reads return in issue order.
- Write latency: RAM is written at E1. No rvalid. A CPU read of the same address granted next returns the new data.
- Idle: no req → ram_we=0, ram_addr holds its previous value, no gnt.
- Simultaneous requests:
  - With MAX_VID_STREAK=4 and both requesting continuously, the grant pattern is V,V,V,V,C repeating.
  - CPU's worst-case wait is MAX_VID_STREAK cycles.
- Reset mid-operation: asserting reset during a gnt or in-flight read clears everything. After release, the first grant follows normal rules.

Optional Feature:
- Macro CHIP8_WP_EN (write-protect of interpreter/font area 0x000–0x1FF).
- Defined:
  - A CPU write with cpu_addr<0x200 is still granted (cpu_gnt pulses) and counts as the CPU slot, but ram_we stays 0.
  - Extra output port wp_violation (1 bit) pulses for one cycle, aligned with cpu_gnt.
  - Reset value of wp_violation is 0.
- Undefined: port absent; all writes pass through.

Test Plan:
- CPU read alone: preload RAM[0x200]=0xA2, cpu_req=1, cpu_we=0, cpu_addr=0x200 → cpu_gnt 1 cycle later; cpu_rvalid=1 with cpu_rdata=0xA2 exactly 2 cycles after the gnt cycle; ram_we never 1.
- CPU write then read: write 0x5C to 0x300, then read 0x300 back-to-back → ram_we=1 for one cycle with ram_addr=0x300 and ram_d=0x5C; read returns 0x5C.
- Contention: vid_req and cpu_req held high for 20 cycles with MAX_VID_STREAK=4 → grants follow the pattern V,V,V,V,C repeating (4 CPU grants, 16 video grants); no cycle has both gnt high.
- Interleaved reads: alternating V/C grants to addresses holding 0x11 and 0x22 → each rvalid goes to the correct requester with the correct data, in issue order.
- Reset mid-read: assert reset the cycle after vid_gnt → no vid_rvalid afterwards; all outputs 0 during reset; normal grant on the first request after release.
- CHIP8_WP_EN: CPU write of 0xFF to 0x050 → cpu_gnt=1 and wp_violation=1 in the same cycle, ram_we=0; read back returns the original value. The same write to 0x250 writes normally with no violation.

Source files
------------

// File: rtl/chip8_mem_arbiter.sv
// chip8_mem_arbiter
// Shares the single-port CHIP-8 main RAM between the CPU (read/write) and
// the VGA pixel generator (read-only framebuffer fetch). Video has fixed
// priority, but a streak counter limits it to MAX_VID_STREAK consecutive
// grants while the CPU is waiting. At most one access is issued per cycle.
// Read data comes back two cycles after the grant cycle. A two-stage owner
// tag pipeline routes it to the requester that issued the read.
//
// Optional feature: define CHIP8_WP_EN to write-protect 0x000-0x1FF.
// A protected CPU write is still granted, but ram_we stays low and
// wp_violation pulses together with cpu_gnt.

module chip8_mem_arbiter #(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 8,
    parameter int MAX_VID_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_d,
    input  logic [DATA_W-1:0] ram_q
`ifdef CHIP8_WP_EN
    ,
    output logic              wp_violation
`endif
);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_CPU  = 2'd1,
        TAG_VID  = 2'd2
    } owner_tag_t;

    logic [3:0] streak;
    logic       vid_wins;
    logic       cpu_wins;
    logic       cpu_write_ok;
    logic       cpu_wp_hit;
    owner_tag_t tag_issue;
    owner_tag_t tag_ram;

    // Pick this cycle's winner and decide whether a CPU write may reach the RAM
    always_comb begin
        vid_wins = vid_req && (!cpu_req || (streak < 4'(MAX_VID_STREAK)));
        cpu_wins = cpu_req && !vid_wins;
`ifdef CHIP8_WP_EN
        cpu_wp_hit = cpu_we && (cpu_addr < ADDR_W'('h200));
`else
        cpu_wp_hit = 1'b0;
`endif
        cpu_write_ok = cpu_we && !cpu_wp_hit;
    end

    // Register the winner's access onto the RAM port and raise its grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_d     <= '0;
            cpu_gnt   <= 1'b0;
            vid_gnt   <= 1'b0;
            tag_issue <= TAG_NONE;
        end else begin
            cpu_gnt <= cpu_wins;
            vid_gnt <= vid_wins;
            ram_we  <= cpu_wins && cpu_write_ok;
            if (vid_wins) begin
                ram_addr  <= vid_addr;
                tag_issue <= TAG_VID;
            end else if (cpu_wins) begin
                ram_addr  <= cpu_addr;
                ram_d     <= cpu_wdata;
                tag_issue <= cpu_we ? TAG_NONE : TAG_CPU;
            end else begin
                tag_issue <= TAG_NONE;
            end
        end
    end

`ifdef CHIP8_WP_EN
    // Flag a blocked write to the protected interpreter/font area
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_violation <= 1'b0;
        end else begin
            wp_violation <= cpu_wins && cpu_wp_hit;
        end
    end
`endif

    // Count back-to-back video grants while the CPU waits, saturating at the limit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streak <= 4'd0;
        end else if (!cpu_req || cpu_wins) begin
            streak <= 4'd0;
        end else if (vid_wins && (streak < 4'(MAX_VID_STREAK))) begin
            streak <= streak + 4'd1;
        end
    end

    // Follow each read through the RAM and hand its data to the owner
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_ram    <= TAG_NONE;
            cpu_rvalid <= 1'b0;
            vid_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            vid_rdata  <= '0;
        end else begin
            tag_ram    <= tag_issue;
            cpu_rvalid <= (tag_ram == TAG_CPU);
            vid_rvalid <= (tag_ram == TAG_VID);
            if (tag_ram == TAG_CPU) begin
                cpu_rdata <= ram_q;
            end
            if (tag_ram == TAG_VID) begin
                vid_rdata <= ram_q;
            end
        end
    end

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Self-checking bench for chip8_mem_arbiter with a behavioural 4 KiB
// synchronous-read RAM. Inputs change and outputs are sampled on the
// falling edge. Define CHIP8_WP_EN to exercise the write-protect option.

module tb_chip8_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [11:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [7:0]  cpu_rdata;
    logic        vid_req = 1'b0;
    logic [11:0] vid_addr = '0;
    logic        vid_gnt;
    logic        vid_rvalid;
    logic [7:0]  vid_rdata;
    logic [11:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_d;
    logic [7:0]  ram_q;
`ifdef CHIP8_WP_EN
    logic        wp_violation;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [0:4095];

    chip8_mem_arbiter #(
        .ADDR_W(12),
        .DATA_W(8),
        .MAX_VID_STREAK(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cpu_req(cpu_req),
        .cpu_we(cpu_we),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt),
        .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata),
        .vid_req(vid_req),
        .vid_addr(vid_addr),
        .vid_gnt(vid_gnt),
        .vid_rvalid(vid_rvalid),
        .vid_rdata(vid_rdata),
        .ram_addr(ram_addr),
        .ram_we(ram_we),
        .ram_d(ram_d),
        .ram_q(ram_q)
`ifdef CHIP8_WP_EN
        ,
        .wp_violation(wp_violation)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural RAM: preload, then synchronous write and 1-cycle read
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h200] = 8'hA2;
        mem[12'h210] = 8'h11;
        mem[12'h220] = 8'h22;
        mem[12'h050] = 8'h77;
        ram_q = 8'h00;
        forever begin
            @(posedge clk);
            ram_q <= mem[ram_addr];
            if (ram_we) mem[ram_addr] <= ram_d;
        end
    end

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({cpu_gnt, vid_gnt, cpu_rvalid, vid_rvalid, ram_we} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 00000",
                     {cpu_gnt, vid_gnt, cpu_rvalid, vid_rvalid, ram_we});
        end
        checks++;
        if ({ram_addr, ram_d, cpu_rdata, vid_rdata} !== 36'h0) begin
            errors++;
            $display("[TB] FAIL reset_buses: got %h expected 0",
                     {ram_addr, ram_d, cpu_rdata, vid_rdata});
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({cpu_gnt, vid_gnt, ram_we} !== 3'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got %b expected 000", {cpu_gnt, vid_gnt, ram_we});
        end
    endtask

    task automatic test_cpu_read();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h200;
        @(negedge clk);
        checks++;
        if (cpu_gnt !== 1'b1 || vid_gnt !== 1'b0 || ram_addr !== 12'h200 || ram_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cpu_read_gnt: got gnt=%b vgnt=%b addr=%h we=%b expected 1 0 200 0",
                     cpu_gnt, vid_gnt, ram_addr, ram_we);
        end
        cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_rvalid !== 1'b0 || cpu_gnt !== 1'b0 || ram_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cpu_read_early: got rvalid=%b gnt=%b we=%b expected 0 0 0",
                     cpu_rvalid, cpu_gnt, ram_we);
        end
        @(negedge clk);
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'hA2 || vid_rvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cpu_read_data: got rvalid=%b data=%h vrvalid=%b expected 1 a2 0",
                     cpu_rvalid, cpu_rdata, vid_rvalid);
        end
        @(negedge clk);
        checks++;
        if (cpu_rvalid !== 1'b0 || cpu_rdata !== 8'hA2) begin
            errors++;
            $display("[TB] FAIL cpu_read_hold: got rvalid=%b data=%h expected 0 a2", cpu_rvalid, cpu_rdata);
        end
    endtask

    task automatic test_write_read();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h300; cpu_wdata = 8'h5C;
        @(negedge clk);
        checks++;
        if (cpu_gnt !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 12'h300 || ram_d !== 8'h5C) begin
            errors++;
            $display("[TB] FAIL write_issue: got gnt=%b we=%b addr=%h d=%h expected 1 1 300 5c",
                     cpu_gnt, ram_we, ram_addr, ram_d);
        end
        cpu_we = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_gnt !== 1'b1 || ram_we !== 1'b0 || mem[12'h300] !== 8'h5C) begin
            errors++;
            $display("[TB] FAIL read_b2b_gnt: got gnt=%b we=%b mem=%h expected 1 0 5c",
                     cpu_gnt, ram_we, mem[12'h300]);
        end
        cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_rvalid !== 1'b0 || cpu_gnt !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_no_rvalid: got rvalid=%b gnt=%b expected 0 0", cpu_rvalid, cpu_gnt);
        end
        @(negedge clk);
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h5C) begin
            errors++;
            $display("[TB] FAIL read_after_write: got rvalid=%b data=%h expected 1 5c", cpu_rvalid, cpu_rdata);
        end
        @(negedge clk);
        checks++;
        if (ram_we !== 1'b0 || ram_addr !== 12'h300 || cpu_gnt !== 1'b0 || vid_gnt !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_hold: got we=%b addr=%h gnt=%b%b expected 0 300 00",
                     ram_we, ram_addr, cpu_gnt, vid_gnt);
        end
    endtask

    task automatic test_contention();
        int n_cpu = 0;
        int n_vid = 0;
        logic exp_c;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h200;
        vid_req = 1'b1; vid_addr = 12'h210;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            exp_c = ((i % 5) == 4);
            if (cpu_gnt === 1'b1) n_cpu++;
            if (vid_gnt === 1'b1) n_vid++;
            checks++;
            if (cpu_gnt !== exp_c || vid_gnt !== !exp_c) begin
                errors++;
                $display("[TB] FAIL contention_cycle%0d: got cpu=%b vid=%b expected cpu=%b vid=%b",
                         i, cpu_gnt, vid_gnt, exp_c, !exp_c);
            end
        end
        cpu_req = 1'b0; vid_req = 1'b0;
        checks++;
        if (n_cpu != 4 || n_vid != 16) begin
            errors++;
            $display("[TB] FAIL contention_totals: got cpu=%0d vid=%0d expected 4 16", n_cpu, n_vid);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_interleaved();
        // bit set = video request, clear = CPU request
        logic [5:0] pat;
        logic       v;
        pat = 6'b010101;
        for (int j = 0; j < 9; j++) begin
            if (j >= 1 && j <= 6) begin
                v = pat[j-1];
                checks++;
                if (vid_gnt !== v || cpu_gnt !== !v) begin
                    errors++;
                    $display("[TB] FAIL interleave_gnt%0d: got vid=%b cpu=%b expected vid=%b cpu=%b",
                             j - 1, vid_gnt, cpu_gnt, v, !v);
                end
            end
            if (j >= 3) begin
                v = pat[j-3];
                checks++;
                if (vid_rvalid !== v || cpu_rvalid !== !v ||
                    (v && vid_rdata !== 8'h11) || (!v && cpu_rdata !== 8'h22)) begin
                    errors++;
                    $display("[TB] FAIL interleave_rd%0d: got vrv=%b vd=%h crv=%b cd=%h expected vrv=%b 11/22",
                             j - 3, vid_rvalid, vid_rdata, cpu_rvalid, cpu_rdata, v);
                end
            end
            if (j < 6) begin
                vid_req = pat[j]; vid_addr = 12'h210;
                cpu_req = !pat[j]; cpu_we = 1'b0; cpu_addr = 12'h220;
            end else begin
                vid_req = 1'b0; cpu_req = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_write_protect();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h050; cpu_wdata = 8'hFF;
        @(negedge clk);
`ifdef CHIP8_WP_EN
        checks++;
        if (cpu_gnt !== 1'b1 || wp_violation !== 1'b1 || ram_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wp_block: got gnt=%b wp=%b we=%b expected 1 1 0", cpu_gnt, wp_violation, ram_we);
        end
        cpu_we = 1'b0;
        @(negedge clk);
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h77) begin
            errors++;
            $display("[TB] FAIL wp_readback: got rvalid=%b data=%h expected 1 77", cpu_rvalid, cpu_rdata);
        end
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h250; cpu_wdata = 8'hFF;
        @(negedge clk);
        checks++;
        if (cpu_gnt !== 1'b1 || wp_violation !== 1'b0 || ram_we !== 1'b1 || ram_addr !== 12'h250) begin
            errors++;
            $display("[TB] FAIL wp_pass: got gnt=%b wp=%b we=%b addr=%h expected 1 0 1 250",
                     cpu_gnt, wp_violation, ram_we, ram_addr);
        end
`else
        checks++;
        if (cpu_gnt !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 12'h050 || ram_d !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL low_write_pass: got gnt=%b we=%b addr=%h d=%h expected 1 1 050 ff",
                     cpu_gnt, ram_we, ram_addr, ram_d);
        end
`endif
        cpu_req = 1'b0; cpu_we = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        vid_req = 1'b1; vid_addr = 12'h210;
        @(negedge clk);
        checks++;
        if (vid_gnt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_gnt: got %b expected 1", vid_gnt);
        end
        vid_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({cpu_gnt, vid_gnt, cpu_rvalid, vid_rvalid, ram_we, ram_addr, ram_d, cpu_rdata, vid_rdata} !== 41'h0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got %h expected 0",
                     {cpu_gnt, vid_gnt, cpu_rvalid, vid_rvalid, ram_we, ram_addr, ram_d, cpu_rdata, vid_rdata});
        end
        @(negedge clk);
        checks++;
        if (vid_rvalid !== 1'b0 || vid_rdata !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midreset_hold: got rvalid=%b data=%h expected 0 00", vid_rvalid, vid_rdata);
        end
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (vid_rvalid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midreset_stale%0d: got vid_rvalid=%b expected 0", k, vid_rvalid);
            end
        end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h200;
        @(negedge clk);
        checks++;
        if (cpu_gnt !== 1'b1 || ram_addr !== 12'h200) begin
            errors++;
            $display("[TB] FAIL postreset_gnt: got gnt=%b addr=%h expected 1 200", cpu_gnt, ram_addr);
        end
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'hA2) begin
            errors++;
            $display("[TB] FAIL postreset_read: got rvalid=%b data=%h expected 1 a2", cpu_rvalid, cpu_rdata);
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_cpu_read();
        test_write_read();
        test_contention();
        test_interleaved();
        test_write_protect();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
